// File: rtl/mips_pkg.sv
// Shared types for the MIPS pipeline: EX/MEM control bundle, skid-buffer
// occupancy states and the payload width helper.
package mips_pkg;

    typedef struct packed {
        logic memRead;
        logic memWrite;
        logic branch;
        logic regWrite;
        logic memToReg;
    } ctrl_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    // Packed data payload: branchTarget, zeroFlag, ALUResult, readData2, writeReg.
    function automatic int payloadWidth(input int dataW, input int regW);
        return 3 * dataW + regW + 1;
    endfunction

endpackage

// File: rtl/pipe_entry.sv
// One payload slot of the EX/MEM stage: data plus control bundle with a load
// enable, and a control-only clear so a drained slot reads as a bubble.
module pipe_entry
    import mips_pkg::*;
#(
    parameter int W = 102
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load_i,
    input  logic         clear_i,
    input  logic [W-1:0] data_i,
    input  ctrl_t        ctrl_i,
    output logic [W-1:0] data_o,
    output ctrl_t        ctrl_o
);

    logic [W-1:0] data_q;
    ctrl_t        ctrl_q;

    // Data is kept on clear so the MEM side sees stable values across bubbles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_q <= '0;
            ctrl_q <= '0;
        end else if (load_i) begin
            data_q <= data_i;
            ctrl_q <= ctrl_i;
        end else if (clear_i) begin
            ctrl_q <= '0;
        end
    end

    assign data_o = data_q;
    assign ctrl_o = ctrl_q;

endmodule

// File: rtl/ex_mem_pipe_stage.sv
// EX/MEM pipeline register with valid/ready handshakes, optional two-entry
// skid buffer, flush, cache-hit gating and a saturating stall counter.
module ex_mem_pipe_stage
    import mips_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              inValid,
    output logic              inReady,
    input  logic [DATA_W-1:0] branchTarget,
    input  logic              zeroFlag,
    input  logic [DATA_W-1:0] ALUResult,
    input  logic [DATA_W-1:0] readData2,
    input  logic [REG_W-1:0]  writeReg,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              Branch,
    input  logic              RegWrite,
    input  logic              MemToReg,
    input  logic              flush,
    input  logic              hit,
    input  logic              outReady,
    output logic              outValid,
    output logic [DATA_W-1:0] branchTargetOut,
    output logic              zeroFlagOut,
    output logic [DATA_W-1:0] ALUResultOut,
    output logic [DATA_W-1:0] readData2Out,
    output logic [REG_W-1:0]  writeRegOut,
    output logic              MemReadOut,
    output logic              MemWriteOut,
    output logic              BranchOut,
    output logic              RegWriteOut,
    output logic              MemToRegOut,
    output logic              hitOut,
    output logic [CNT_W-1:0]  stallCount
);

    localparam int PAY_W = payloadWidth(DATA_W, REG_W);

    state_t            state_q, state_d;
    logic              accept, consume;
    logic              loadOut, loadSkid, clearOut, selSkid;
    logic [PAY_W-1:0]  inData, skidData, outData;
    ctrl_t             inCtrl, skidCtrl, outCtrl;
    logic              hit_q;
    logic [CNT_W-1:0]  stallCount_q;

    assign inData = {branchTarget, zeroFlag, ALUResult, readData2, writeReg};
    assign inCtrl = '{MemRead, MemWrite, Branch, RegWrite, MemToReg};

    assign outValid = (state_q != EMPTY);
    assign accept   = inValid && inReady;
    assign consume  = outValid && outReady && hit;

    // With a skid slot, ready depends only on registered state; without one
    // the upstream sees the downstream handshake combinationally.
    if (SKID != 0) begin : gSkidReady
        assign inReady = (state_q != TWO);
    end else begin : gCombReady
        assign inReady = !outValid || (outReady && hit);
    end

    always_comb begin
        state_d  = state_q;
        loadOut  = 1'b0;
        loadSkid = 1'b0;
        clearOut = 1'b0;
        selSkid  = 1'b0;
        if (flush) begin
            state_d  = EMPTY;
            clearOut = 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = ONE;
                        loadOut = 1'b1;
                    end
                end
                ONE: begin
                    if (consume && accept) begin
                        loadOut = 1'b1;
                    end else if (consume) begin
                        state_d  = EMPTY;
                        clearOut = 1'b1;
                    end else if (accept) begin
                        state_d  = TWO;
                        loadSkid = 1'b1;
                    end
                end
                TWO: begin
                    if (consume) begin
                        state_d = ONE;
                        loadOut = 1'b1;
                        selSkid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    pipe_entry #(.W(PAY_W)) uOutEntry (
        .clock   (clock),
        .reset   (reset),
        .load_i  (loadOut),
        .clear_i (clearOut),
        .data_i  (selSkid ? skidData : inData),
        .ctrl_i  (selSkid ? skidCtrl : inCtrl),
        .data_o  (outData),
        .ctrl_o  (outCtrl)
    );

    pipe_entry #(.W(PAY_W)) uSkidEntry (
        .clock   (clock),
        .reset   (reset),
        .load_i  (loadSkid),
        .clear_i (flush),
        .data_i  (inData),
        .ctrl_i  (inCtrl),
        .data_o  (skidData),
        .ctrl_o  (skidCtrl)
    );

    // Flushed cycles are not stalls; the counter sticks at all-ones.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stallCount_q <= '0;
            hit_q        <= 1'b0;
        end else begin
            hit_q <= hit;
            if (outValid && !(outReady && hit) && !flush && (stallCount_q != '1)) begin
                stallCount_q <= stallCount_q + CNT_W'(1);
            end
        end
    end

    assign {branchTargetOut, zeroFlagOut, ALUResultOut, readData2Out, writeRegOut} = outData;
    assign MemReadOut  = outCtrl.memRead;
    assign MemWriteOut = outCtrl.memWrite;
    assign BranchOut   = outCtrl.branch;
    assign RegWriteOut = outCtrl.regWrite;
    assign MemToRegOut = outCtrl.memToReg;
    assign hitOut      = hit_q;
    assign stallCount  = stallCount_q;

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Scoreboard bench for ex_mem_pipe_stage: default skid build, a 4-bit stall
// counter build and a SKID=0 build, driven with directed vectors.
module tb_ex_mem_pipe_stage;

    typedef logic [106:0] vec_t;

    // {branchTarget, zeroFlag, ALUResult, readData2, writeReg, MemRead, MemWrite, Branch, RegWrite, MemToReg}
    localparam vec_t VZ = '0;
    localparam vec_t VA = {32'h0000_0000, 1'b0, 32'h0000_00A5, 32'h0000_0000, 5'd5,  5'b00010};
    localparam vec_t VB = {32'h0040_0010, 1'b1, 32'h1111_0001, 32'hDEAD_0001, 5'd1,  5'b10011};
    localparam vec_t VC = {32'h0040_0020, 1'b0, 32'h2222_0002, 32'hDEAD_0002, 5'd2,  5'b01000};
    localparam vec_t VD = {32'h0040_0030, 1'b1, 32'h3333_0003, 32'hDEAD_0003, 5'd3,  5'b00100};
    localparam vec_t VE = {32'h0040_0040, 1'b0, 32'h4444_0004, 32'hDEAD_0004, 5'd31, 5'b00010};
    localparam vec_t VF = {32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFF, 32'h5555_5555, 5'd7,  5'b11111};
    localparam vec_t VG = {32'h1234_5678, 1'b0, 32'h8765_4321, 32'hAAAA_AAAA, 5'd9,  5'b01010};
    localparam vec_t VH = {32'h0BAD_0BAD, 1'b1, 32'hCAFE_F00D, 32'h0F0F_0F0F, 5'd12, 5'b10101};

    logic        clock, reset;
    logic [31:0] branchTarget, ALUResult, readData2;
    logic        zeroFlag;
    logic [4:0]  writeReg;
    logic        MemRead, MemWrite, Branch, RegWrite, MemToReg;

    logic        inValid, outReady, hit, flush;
    logic        inReady, outValid, zeroFlagOut, hitOut;
    logic [31:0] branchTargetOut, ALUResultOut, readData2Out;
    logic [4:0]  writeRegOut;
    logic        MemReadOut, MemWriteOut, BranchOut, RegWriteOut, MemToRegOut;
    logic [15:0] stallCount;

    logic        inValid1, outReady1, hit1, flush1;
    logic        inReady1, outValid1, zeroFlagOut1, hitOut1;
    logic [31:0] branchTargetOut1, ALUResultOut1, readData2Out1;
    logic [4:0]  writeRegOut1;
    logic        MemReadOut1, MemWriteOut1, BranchOut1, RegWriteOut1, MemToRegOut1;
    logic [3:0]  stallCount1;

    logic        inValid2, outReady2, hit2, flush2;
    logic        inReady2, outValid2, zeroFlagOut2, hitOut2;
    logic [31:0] branchTargetOut2, ALUResultOut2, readData2Out2;
    logic [4:0]  writeRegOut2;
    logic        MemReadOut2, MemWriteOut2, BranchOut2, RegWriteOut2, MemToRegOut2;
    logic [15:0] stallCount2;

    int   checks = 0;
    int   errors = 0;
    int   delivered = 0;
    vec_t expQ[$];
    vec_t inVec, outVec;

    assign inVec  = {branchTarget, zeroFlag, ALUResult, readData2, writeReg,
                     MemRead, MemWrite, Branch, RegWrite, MemToReg};
    assign outVec = {branchTargetOut, zeroFlagOut, ALUResultOut, readData2Out, writeRegOut,
                     MemReadOut, MemWriteOut, BranchOut, RegWriteOut, MemToRegOut};

    ex_mem_pipe_stage #(.DATA_W(32), .REG_W(5), .SKID(1), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .inValid(inValid), .inReady(inReady),
        .branchTarget(branchTarget), .ALUResult(ALUResult), .readData2(readData2),
        .zeroFlag(zeroFlag), .writeReg(writeReg), .MemRead(MemRead), .MemWrite(MemWrite),
        .Branch(Branch), .RegWrite(RegWrite), .MemToReg(MemToReg), .flush(flush), .hit(hit),
        .outReady(outReady), .outValid(outValid), .branchTargetOut(branchTargetOut),
        .zeroFlagOut(zeroFlagOut), .ALUResultOut(ALUResultOut), .readData2Out(readData2Out),
        .writeRegOut(writeRegOut), .MemReadOut(MemReadOut), .MemWriteOut(MemWriteOut),
        .BranchOut(BranchOut), .RegWriteOut(RegWriteOut), .MemToRegOut(MemToRegOut),
        .hitOut(hitOut), .stallCount(stallCount)
    );

    ex_mem_pipe_stage #(.DATA_W(32), .REG_W(5), .SKID(1), .CNT_W(4)) dutCnt4 (
        .clock(clock), .reset(reset), .inValid(inValid1), .inReady(inReady1),
        .branchTarget(branchTarget), .ALUResult(ALUResult), .readData2(readData2),
        .zeroFlag(zeroFlag), .writeReg(writeReg), .MemRead(MemRead), .MemWrite(MemWrite),
        .Branch(Branch), .RegWrite(RegWrite), .MemToReg(MemToReg), .flush(flush1), .hit(hit1),
        .outReady(outReady1), .outValid(outValid1), .branchTargetOut(branchTargetOut1),
        .zeroFlagOut(zeroFlagOut1), .ALUResultOut(ALUResultOut1), .readData2Out(readData2Out1),
        .writeRegOut(writeRegOut1), .MemReadOut(MemReadOut1), .MemWriteOut(MemWriteOut1),
        .BranchOut(BranchOut1), .RegWriteOut(RegWriteOut1), .MemToRegOut(MemToRegOut1),
        .hitOut(hitOut1), .stallCount(stallCount1)
    );

    ex_mem_pipe_stage #(.DATA_W(32), .REG_W(5), .SKID(0), .CNT_W(16)) dutNoSkid (
        .clock(clock), .reset(reset), .inValid(inValid2), .inReady(inReady2),
        .branchTarget(branchTarget), .ALUResult(ALUResult), .readData2(readData2),
        .zeroFlag(zeroFlag), .writeReg(writeReg), .MemRead(MemRead), .MemWrite(MemWrite),
        .Branch(Branch), .RegWrite(RegWrite), .MemToReg(MemToReg), .flush(flush2), .hit(hit2),
        .outReady(outReady2), .outValid(outValid2), .branchTargetOut(branchTargetOut2),
        .zeroFlagOut(zeroFlagOut2), .ALUResultOut(ALUResultOut2), .readData2Out(readData2Out2),
        .writeRegOut(writeRegOut2), .MemReadOut(MemReadOut2), .MemWriteOut(MemWriteOut2),
        .BranchOut(BranchOut2), .RegWriteOut(RegWriteOut2), .MemToRegOut(MemToRegOut2),
        .hitOut(hitOut2), .stallCount(stallCount2)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic setPayload(input vec_t v);
        {branchTarget, zeroFlag, ALUResult, readData2, writeReg,
         MemRead, MemWrite, Branch, RegWrite, MemToReg} = v;
    endtask

    // Holds the given inputs on the main instance across one rising edge.
    task automatic applyStimulus(input vec_t v, input logic vld, input logic rdy,
                                 input logic h, input logic fl);
        setPayload(v);
        inValid  = vld;
        outReady = rdy;
        hit      = h;
        flush    = fl;
        @(posedge clock);
        #1;
    endtask

    // Expected-response side: every accepted payload is queued; flush and reset discard.
    always @(negedge clock) begin
        if (reset || flush) begin
            expQ.delete();
        end else if (inValid && inReady) begin
            expQ.push_back(inVec);
        end
    end

    // Monitor: bubbles must carry no control, transfers must match the queue head.
    always @(negedge clock) begin
        if (!reset) begin
            if (!outValid) begin
                checkOutput("bubbleCtrl", {MemReadOut, MemWriteOut, BranchOut, RegWriteOut, MemToRegOut}, 5'b0);
            end
            if (outValid && outReady && hit && !flush) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL scoreboard actual=%h expected=none", outVec);
                end else begin
                    vec_t exp;
                    exp = expQ.pop_front();
                    if (outVec !== exp) begin
                        errors++;
                        $display("[TB] FAIL scoreboard actual=%h expected=%h", outVec, exp);
                    end
                end
                delivered++;
            end
        end
    end

    initial begin
        int k;
        logic expReady;
        setPayload(VZ);
        inValid = 0;  outReady = 0;  hit = 0;  flush = 0;
        inValid1 = 0; outReady1 = 0; hit1 = 0; flush1 = 0;
        inValid2 = 0; outReady2 = 0; hit2 = 0; flush2 = 0;
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("rstOutValid", outValid, 1'b0);
        checkOutput("rstInReady", inReady, 1'b1);
        checkOutput("rstPayload", outVec, VZ);
        checkOutput("rstHitOut", hitOut, 1'b0);
        checkOutput("rstStall", stallCount, 16'd0);
        #2 reset = 1'b0;
        @(posedge clock);
        #1;

        // Single transfer with one-cycle latency, then drain to a bubble.
        applyStimulus(VA, 1, 1, 1, 0);
        checkOutput("latValid", outValid, 1'b1);
        checkOutput("latALU", ALUResultOut, 32'h0000_00A5);
        checkOutput("latRegWrite", RegWriteOut, 1'b1);
        checkOutput("latWriteReg", writeRegOut, 5'd5);
        applyStimulus(VZ, 0, 1, 1, 0);
        checkOutput("drainValid", outValid, 1'b0);
        checkOutput("drainHoldALU", ALUResultOut, 32'h0000_00A5);
        checkOutput("drainRegWrite", RegWriteOut, 1'b0);
        checkOutput("hitOutHigh", hitOut, 1'b1);

        // Cache misses fill the skid buffer; three blocked cycles with output valid.
        applyStimulus(VB, 1, 1, 0, 0);
        applyStimulus(VC, 1, 1, 0, 0);
        applyStimulus(VD, 1, 1, 0, 0);
        applyStimulus(VD, 1, 1, 0, 0);
        checkOutput("twoInReady", inReady, 1'b0);
        checkOutput("twoStall", stallCount, 16'd3);
        checkOutput("twoHeadHeld", outVec, VB);
        checkOutput("hitOutLow", hitOut, 1'b0);
        applyStimulus(VD, 1, 1, 1, 0);
        checkOutput("skidToOut", outVec, VC);
        checkOutput("oneInReady", inReady, 1'b1);
        applyStimulus(VD, 1, 1, 1, 0);
        applyStimulus(VE, 1, 1, 1, 0);
        applyStimulus(VZ, 0, 1, 1, 0);
        checkOutput("streamEmpty", outValid, 1'b0);
        checkOutput("streamStall", stallCount, 16'd3);
        checkOutput("streamHoldALU", ALUResultOut, 32'h4444_0004);
        checkOutput("streamDelivered", delivered, 5);

        // Flush while full with a pending input; nothing may survive.
        applyStimulus(VF, 1, 0, 1, 0);
        applyStimulus(VG, 1, 0, 1, 0);
        checkOutput("fillInReady", inReady, 1'b0);
        applyStimulus(VH, 1, 0, 1, 1);
        checkOutput("flushValid", outValid, 1'b0);
        checkOutput("flushCtrl", {MemReadOut, MemWriteOut, BranchOut, RegWriteOut, MemToRegOut}, 5'b0);
        checkOutput("flushInReady", inReady, 1'b1);
        checkOutput("flushStall", stallCount, 16'd4);
        applyStimulus(VZ, 0, 1, 1, 0);
        checkOutput("postFlushValid", outValid, 1'b0);
        applyStimulus(VD, 1, 1, 1, 1);
        checkOutput("flushDropValid", outValid, 1'b0);
        applyStimulus(VZ, 0, 1, 1, 0);
        checkOutput("flushDropAfter", outValid, 1'b0);
        checkOutput("flushQueueEmpty", expQ.size(), 0);

        // Asynchronous reset while both slots are occupied.
        applyStimulus(VB, 1, 0, 1, 0);
        applyStimulus(VC, 1, 0, 1, 0);
        checkOutput("preRstInReady", inReady, 1'b0);
        checkOutput("preRstStall", stallCount, 16'd5);
        inValid = 1'b0;
        #2 reset = 1'b1;
        #1;
        checkOutput("asyncRstValid", outValid, 1'b0);
        checkOutput("asyncRstInReady", inReady, 1'b1);
        checkOutput("asyncRstPayload", outVec, VZ);
        checkOutput("asyncRstStall", stallCount, 16'd0);
        @(posedge clock);
        #1;
        checkOutput("nextRstValid", outValid, 1'b0);
        checkOutput("nextRstHitOut", hitOut, 1'b0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("postRstValid", outValid, 1'b0);

        // 4-bit counter: one entry held for 20 blocked cycles.
        setPayload(VF);
        inValid1 = 1; outReady1 = 0; hit1 = 1;
        @(posedge clock);
        #1;
        inValid1 = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock);
            #1;
            if (i == 13) checkOutput("cnt4Below", stallCount1, 4'd14);
        end
        checkOutput("cnt4Sat", stallCount1, 4'd15);
        checkOutput("cnt4Held", ALUResultOut1, 32'hFFFF_FFFF);

        // No skid slot: outReady toggles, one transfer per ready cycle.
        setPayload(VZ);
        k = 0;
        for (int c = 0; c < 6; c++) begin
            ALUResult = 32'h0000_0100 + k;
            inValid2  = 1;
            hit2      = 1;
            outReady2 = (c % 2 == 0);
            expReady  = (c % 2 == 0);
            #3;
            checkOutput("noSkidReady", inReady2, expReady);
            if (c == 2) checkOutput("noSkidOut0", ALUResultOut2, 32'h0000_0100);
            if (c == 4) checkOutput("noSkidOut1", ALUResultOut2, 32'h0000_0101);
            @(posedge clock);
            #1;
            if (expReady) k++;
        end
        checkOutput("noSkidHeld", ALUResultOut2, 32'h0000_0102);
        outReady2 = 0;
        #1 checkOutput("combReadyLow", inReady2, 1'b0);
        outReady2 = 1;
        #1 checkOutput("combReadyHigh", inReady2, 1'b1);
        hit2 = 0;
        #1 checkOutput("combReadyMiss", inReady2, 1'b0);
        inValid2 = 0;
        outReady2 = 0;
        @(posedge clock);
        #1;

        checkOutput("finalQueueEmpty", expQ.size(), 0);
        checkOutput("finalDelivered", delivered, 5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
